// File: rtl/relogio_param_if.sv
// relogio_param_if: load/enable inputs and encoded digit outputs of the clock.
// master drives EN/LD/load digits (and alarm controls); slave is the clock itself.
interface relogio_param_if;
  logic       EN;
  logic       LD;
  logic [1:0] H_in1;
  logic [3:0] H_in0;
  logic [3:0] M_in1;
  logic [3:0] M_in0;
  logic       PM_in;
  logic [9:0] H_out1;
  logic [9:0] H_out0;
  logic [9:0] M_out1;
  logic [9:0] M_out0;
  logic [9:0] S_out1;
  logic [9:0] S_out0;
  logic       PM;
  logic       tick;
`ifdef RELOGIO_ALARM_EN
  logic       AL_LD;
  logic       AL_ACK;
  logic       AL_ON;

  modport master (
    output EN, LD, H_in1, H_in0, M_in1, M_in0, PM_in, AL_LD, AL_ACK,
    input  H_out1, H_out0, M_out1, M_out0, S_out1, S_out0, PM, tick, AL_ON
  );
  modport slave (
    input  EN, LD, H_in1, H_in0, M_in1, M_in0, PM_in, AL_LD, AL_ACK,
    output H_out1, H_out0, M_out1, M_out0, S_out1, S_out0, PM, tick, AL_ON
  );
`else
  modport master (
    output EN, LD, H_in1, H_in0, M_in1, M_in0, PM_in,
    input  H_out1, H_out0, M_out1, M_out0, S_out1, S_out0, PM, tick
  );
  modport slave (
    input  EN, LD, H_in1, H_in0, M_in1, M_in0, PM_in,
    output H_out1, H_out0, M_out1, M_out0, S_out1, S_out0, PM, tick
  );
`endif
endinterface

// File: rtl/relogio_param.sv
// relogio_param: HH:MM:SS clock with prescaler, 12h/24h mode, selectable digit encoding.
// Ports: clk, reset (async, active-high), bus (relogio_param_if.slave). Optional alarm: RELOGIO_ALARM_EN.
module relogio_param #(
  parameter int TICK_DIV  = 1,
  parameter int HOUR_MODE = 24,
  parameter int ENC       = 0
) (
  input logic            clk,
  input logic            reset,
  relogio_param_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam bit H12 = (HOUR_MODE == 12);
  localparam logic [1:0] RH1 = H12 ? 2'd1 : 2'd0;
  localparam logic [3:0] RH0 = H12 ? 4'd2 : 4'd0;

  logic [1:0]    h1, h1_n;
  logic [3:0]    h0, h0_n;
  logic [2:0]    m1, m1_n;
  logic [3:0]    m0, m0_n;
  logic [2:0]    s1, s1_n;
  logic [3:0]    s0, s0_n;
  logic          pm, pm_n;
  logic [PW-1:0] pre, pre_n;
  logic          tick_q, tick_n;
  logic          ld_ok;

  function automatic logic hr_ok(logic [1:0] t, logic [3:0] u);
    if (u > 4'd9) return 1'b0;
    if (H12) return (t == 2'd0 && u != 4'd0) || (t == 2'd1 && u <= 4'd2);
    return (t < 2'd2) || (t == 2'd2 && u <= 4'd3);
  endfunction

  // Johnson: 0..5 fill ones from the LSB, 6..9 drain them from the LSB.
  function automatic logic [9:0] enc(logic [3:0] d);
    logic [9:0] o;
    o = '0;
    if (ENC == 1) begin
      o = 10'd1 << d;
    end else if (ENC == 2) begin
      o = {6'd0, d};
    end else if (d <= 4'd5) begin
      o[4:0] = 5'b11111 >> (4'd5 - d);
    end else begin
      o[4:0] = 5'b11111 << (d - 4'd5);
    end
    return o;
  endfunction

  assign ld_ok = hr_ok(bus.H_in1, bus.H_in0)
              && bus.M_in1 <= 4'd5 && bus.M_in0 <= 4'd9;

  always_comb begin
    h1_n   = h1;
    h0_n   = h0;
    m1_n   = m1;
    m0_n   = m0;
    s1_n   = s1;
    s0_n   = s0;
    pm_n   = pm;
    pre_n  = pre;
    tick_n = 1'b0;
    if (bus.LD && ld_ok) begin
      h1_n  = bus.H_in1;
      h0_n  = bus.H_in0;
      m1_n  = bus.M_in1[2:0];
      m0_n  = bus.M_in0;
      s1_n  = '0;
      s0_n  = '0;
      pm_n  = H12 ? bus.PM_in : 1'b0;
      pre_n = '0;
    end else if (bus.EN && pre == PMAX) begin
      pre_n  = '0;
      tick_n = 1'b1;
      if (s0 != 4'd9) begin
        s0_n = s0 + 4'd1;
      end else begin
        s0_n = '0;
        if (s1 != 3'd5) begin
          s1_n = s1 + 3'd1;
        end else begin
          s1_n = '0;
          if (m0 != 4'd9) begin
            m0_n = m0 + 4'd1;
          end else begin
            m0_n = '0;
            if (m1 != 3'd5) begin
              m1_n = m1 + 3'd1;
            end else begin
              m1_n = '0;
              // Hour rollover: 11->12 flips meridiem, 12->01 does not.
              if (H12 && h1 == 2'd1 && h0 == 4'd1) begin
                h0_n = 4'd2;
                pm_n = ~pm;
              end else if (H12 && h1 == 2'd1 && h0 == 4'd2) begin
                h1_n = 2'd0;
                h0_n = 4'd1;
              end else if (!H12 && h1 == 2'd2 && h0 == 4'd3) begin
                h1_n = 2'd0;
                h0_n = 4'd0;
              end else if (h0 == 4'd9) begin
                h1_n = h1 + 2'd1;
                h0_n = 4'd0;
              end else begin
                h0_n = h0 + 4'd1;
              end
            end
          end
        end
      end
    end else if (bus.EN) begin
      pre_n = pre + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h1     <= RH1;
      h0     <= RH0;
      m1     <= '0;
      m0     <= '0;
      s1     <= '0;
      s0     <= '0;
      pm     <= 1'b0;
      pre    <= '0;
      tick_q <= 1'b0;
    end else begin
      h1     <= h1_n;
      h0     <= h0_n;
      m1     <= m1_n;
      m0     <= m0_n;
      s1     <= s1_n;
      s0     <= s0_n;
      pm     <= pm_n;
      pre    <= pre_n;
      tick_q <= tick_n;
    end
  end

  assign bus.H_out1 = enc({2'd0, h1});
  assign bus.H_out0 = enc(h0);
  assign bus.M_out1 = enc({1'b0, m1});
  assign bus.M_out0 = enc(m0);
  assign bus.S_out1 = enc({1'b0, s1});
  assign bus.S_out0 = enc(s0);
  assign bus.PM     = pm;
  assign bus.tick   = tick_q;

`ifdef RELOGIO_ALARM_EN
  logic [1:0] ah1;
  logic [3:0] ah0;
  logic [2:0] am1;
  logic [3:0] am0;
  logic       apm;
  logic       al_on;
  logic       al_hit;

  // Match against the time being entered on an advancing edge only.
  always_comb begin
    al_hit = tick_n
          && h1_n == ah1 && h0_n == ah0
          && m1_n == am1 && m0_n == am0
          && s1_n == 3'd0 && s0_n == 4'd0
          && (!H12 || pm_n == apm);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ah1   <= RH1;
      ah0   <= RH0;
      am1   <= '0;
      am0   <= '0;
      apm   <= 1'b0;
      al_on <= 1'b0;
    end else begin
      if (bus.AL_LD && ld_ok) begin
        ah1 <= bus.H_in1;
        ah0 <= bus.H_in0;
        am1 <= bus.M_in1[2:0];
        am0 <= bus.M_in0;
        apm <= H12 ? bus.PM_in : 1'b0;
      end
      al_on <= al_hit | (al_on & ~bus.AL_ACK);
    end
  end

  assign bus.AL_ON = al_on;
`endif

endmodule

// File: tb/tb_relogio_param.sv
// tb_relogio_param: three clock variants checked against a seconds-of-day model.
// Directed scenarios followed by randomized loads/enables; alarm covered when RELOGIO_ALARM_EN.
module tb_relogio_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, ld, pm_in, al_ld, al_ack;
  logic [1:0] hi1;
  logic [3:0] hi0, mi1, mi0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  relogio_param_if bi[3] ();

  for (genvar g = 0; g < 3; g++) begin : drv
    assign bi[g].EN    = en;
    assign bi[g].LD    = ld;
    assign bi[g].H_in1 = hi1;
    assign bi[g].H_in0 = hi0;
    assign bi[g].M_in1 = mi1;
    assign bi[g].M_in0 = mi0;
    assign bi[g].PM_in = pm_in;
`ifdef RELOGIO_ALARM_EN
    assign bi[g].AL_LD  = al_ld;
    assign bi[g].AL_ACK = al_ack;
`endif
  end

  relogio_param #(.TICK_DIV(1), .HOUR_MODE(24), .ENC(0)) d0 (
    .clk(clk), .reset(reset), .bus(bi[0]));
  relogio_param #(.TICK_DIV(1), .HOUR_MODE(12), .ENC(2)) d1 (
    .clk(clk), .reset(reset), .bus(bi[1]));
  relogio_param #(.TICK_DIV(4), .HOUR_MODE(24), .ENC(1)) d2 (
    .clk(clk), .reset(reset), .bus(bi[2]));

  // Model: time as seconds since midnight (24h), alarm likewise.
  int md[3] = '{24, 12, 24};
  int dv[3] = '{1, 1, 4};
  int ec[3] = '{0, 2, 1};
  int secs[3], pre[3], al_s[3];
  bit tk[3], al_on[3];

  function automatic bit valid_ld(int mode, int t, int u, int mt, int mu);
    int hv;
    if (u > 9 || mt > 5 || mu > 9) return 1'b0;
    hv = t * 10 + u;
    if (mode == 24) return hv <= 23;
    return hv >= 1 && hv <= 12;
  endfunction

  function automatic int load_secs(int mode, int t, int u, int mt, int mu, bit p);
    int hv, h24;
    hv = t * 10 + u;
    h24 = (mode == 24) ? hv : (hv % 12) + (p ? 12 : 0);
    return h24 * 3600 + (mt * 10 + mu) * 60;
  endfunction

  function automatic logic [9:0] encx(int e, int d);
    logic [9:0] o;
    if (e == 1) return 10'd1 << d;
    if (e == 2) return 10'(d);
    case (d)
      0: o = 10'b00000;
      1: o = 10'b00001;
      2: o = 10'b00011;
      3: o = 10'b00111;
      4: o = 10'b01111;
      5: o = 10'b11111;
      6: o = 10'b11110;
      7: o = 10'b11100;
      8: o = 10'b11000;
      default: o = 10'b10000;
    endcase
    return o;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      secs[k] = 0; pre[k] = 0; tk[k] = 0; al_s[k] = 0; al_on[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit ok, adv, hit;
      ok = valid_ld(md[k], hi1, hi0, mi1, mi0);
      adv = 0;
      if (ld && ok) begin
        secs[k] = load_secs(md[k], hi1, hi0, mi1, mi0, pm_in);
        pre[k] = 0; tk[k] = 0;
      end else if (en && pre[k] == dv[k] - 1) begin
        secs[k] = (secs[k] + 1) % 86400;
        pre[k] = 0; tk[k] = 1; adv = 1;
      end else begin
        if (en) pre[k]++;
        tk[k] = 0;
      end
      hit = adv && secs[k] == al_s[k];
      al_on[k] = hit | (al_on[k] & ~al_ack);
      if (al_ld && ok) al_s[k] = load_secs(md[k], hi1, hi0, mi1, mi0, pm_in);
    end
  endtask

  task automatic cmp(string tag, logic [9:0] o, logic [9:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, o, e, $time);
    end
  endtask

  task automatic chk(int k, logic [9:0] h1, logic [9:0] h0,
                     logic [9:0] m1, logic [9:0] m0,
                     logic [9:0] s1, logic [9:0] s0,
                     logic p, logic t);
    int h24, hd, mn, sc;
    h24 = secs[k] / 3600;
    hd = (md[k] == 24) ? h24 : ((h24 % 12 == 0) ? 12 : h24 % 12);
    mn = (secs[k] / 60) % 60;
    sc = secs[k] % 60;
    cmp($sformatf("d%0d_H_out1", k), h1, encx(ec[k], hd / 10));
    cmp($sformatf("d%0d_H_out0", k), h0, encx(ec[k], hd % 10));
    cmp($sformatf("d%0d_M_out1", k), m1, encx(ec[k], mn / 10));
    cmp($sformatf("d%0d_M_out0", k), m0, encx(ec[k], mn % 10));
    cmp($sformatf("d%0d_S_out1", k), s1, encx(ec[k], sc / 10));
    cmp($sformatf("d%0d_S_out0", k), s0, encx(ec[k], sc % 10));
    cmp($sformatf("d%0d_PM", k), 10'(p), 10'(md[k] == 12 && h24 >= 12));
    cmp($sformatf("d%0d_tick", k), 10'(t), 10'(tk[k]));
  endtask

  task automatic chk_all();
    chk(0, bi[0].H_out1, bi[0].H_out0, bi[0].M_out1, bi[0].M_out0,
        bi[0].S_out1, bi[0].S_out0, bi[0].PM, bi[0].tick);
    chk(1, bi[1].H_out1, bi[1].H_out0, bi[1].M_out1, bi[1].M_out0,
        bi[1].S_out1, bi[1].S_out0, bi[1].PM, bi[1].tick);
    chk(2, bi[2].H_out1, bi[2].H_out0, bi[2].M_out1, bi[2].M_out0,
        bi[2].S_out1, bi[2].S_out0, bi[2].PM, bi[2].tick);
`ifdef RELOGIO_ALARM_EN
    cmp("d0_AL_ON", 10'(bi[0].AL_ON), 10'(al_on[0]));
    cmp("d1_AL_ON", 10'(bi[1].AL_ON), 10'(al_on[1]));
    cmp("d2_AL_ON", 10'(bi[2].AL_ON), 10'(al_on[2]));
`endif
  endtask

  task automatic step(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      chk_all();
    end
  endtask

  task automatic set_in(int t, int u, int mt, int mu, bit p);
    hi1 = 2'(t); hi0 = 4'(u); mi1 = 4'(mt); mi0 = 4'(mu); pm_in = p;
  endtask

  task automatic load(int t, int u, int mt, int mu, bit p);
    set_in(t, u, mt, mu, p);
    ld = 1'b1;
    step(1);
    ld = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0; ld = 1'b0; al_ld = 1'b0; al_ack = 1'b0;
    set_in(0, 0, 0, 0, 0);
    model_reset();
    #3;
    chk_all();
    cmp("rst_d0_H_out0_zero", bi[0].H_out0, 10'd0);
    reset = 1'b0;

    en = 1'b1;
    step(10);
    cmp("dir_S_out0_10s", bi[0].S_out0, 10'b00000);
    cmp("dir_S_out1_10s", bi[0].S_out1, 10'b00001);

    load(1, 5, 3, 0, 0);
    cmp("dir_H_out0_15", bi[0].H_out0, 10'b11111);
    step(60);

    load(2, 3, 5, 9, 0);
    step(60);

    load(1, 1, 5, 9, 0);
    step(60);
    cmp("dir_d1_PM_noon", 10'(bi[1].PM), 10'd1);
    load(1, 2, 5, 9, 1);
    step(60);

    load(2, 4, 0, 0, 0);
    step(3);
    load(1, 2, 6, 0, 0);
    step(3);
    load(0, 0, 1, 0, 0);
    step(3);
    en = 1'b0;
    step(20);
    en = 1'b1;

    load(1, 2, 0, 0, 0);
    set_in(1, 2, 0, 1, 0);
    al_ld = 1'b1;
    step(1);
    al_ld = 1'b0;
    step(250);
    al_ack = 1'b1;
    step(1);
    al_ack = 1'b0;
    step(5);

    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk_all();
    #1;
    reset = 1'b0;
    step(7);

    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 39) == 0);
      al_ld = ($urandom_range(0, 59) == 0);
      al_ack = ($urandom_range(0, 29) == 0);
      set_in($urandom_range(0, 3), $urandom_range(0, 11),
             $urandom_range(0, 7), $urandom_range(0, 11),
             1'($urandom_range(0, 1)));
      step(1);
    end
    ld = 1'b0; al_ld = 1'b0; al_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
